md_issue_ctrl: RTL and testbench

- Parametrised multi-cycle execute controller. It sequences mult/div ops held in the DX stage through an external iterative multdiv unit.
- Freezes PC/FD/DX while the op is in flight, then presents the result (or exception code plus status-register destination) for the XM latch.
- Replaces the ad-hoc operand-register and ready-mux logic in the execute stage. Adds squash, cycle counting and an optional watchdog.

---
 rtl/md_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// Multi-cycle execute controller: issues DX mult/div ops to an iterative multdiv unit and
// presents the result (or exception code) to XM. Optional watchdog via `define MD_WATCHDOG_EN.
module md_issue_ctrl #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int STATUS_REG = 30,
    parameter int MULT_EXC   = 4,
    parameter int DIV_EXC    = 5,
    parameter int CNT_W      = 8,
    parameter int WDOG_MAX   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dx_mult,
    input  logic              dx_div,
    input  logic [DATA_W-1:0] dx_opA,
    input  logic [DATA_W-1:0] dx_opB,
    input  logic [REG_AW-1:0] dx_rd,
    input  logic              flush,
    input  logic              md_ready,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic [DATA_W-1:0] md_opA,
    output logic [DATA_W-1:0] md_opB,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              busy,
    output logic [CNT_W-1:0]  md_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef MD_WATCHDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  WDOG_LIM = CNT_W'(WDOG_MAX);
    localparam logic [REG_AW-1:0] STAT_RD  = REG_AW'(STATUS_REG);

    state_t              r_state;
    logic                r_kind_mult;
    logic [REG_AW-1:0]   r_rd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ctrl_mult;
    logic                r_ctrl_div;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic                r_ex_valid;
    logic [DATA_W-1:0]   r_ex_data;
    logic [REG_AW-1:0]   r_ex_dest;
    logic [CNT_W-1:0]    r_md_cycles;

    logic                w_issue;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_wdog_hit;
    logic                w_stall;

    // Status-register code reported for a failed op of the given kind.
    function automatic logic [DATA_W-1:0] exc_code(input logic kind_mult);
        exc_code = kind_mult ? DATA_W'(MULT_EXC) : DATA_W'(DIV_EXC);
    endfunction

    assign w_issue    = (dx_mult | dx_div) & ~flush;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
    assign w_wdog_hit = WDOG_ON & (w_cnt_inc == WDOG_LIM);

    // Stall: combinational issue request in IDLE, held while the op is in flight unless squashed.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_issue;
            S_START: w_stall = ~flush;
            S_WAIT:  w_stall = ~flush;
            S_DONE:  w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_kind_mult <= 1'b0;
            r_rd        <= {REG_AW{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_opa       <= {DATA_W{1'b0}};
            r_opb       <= {DATA_W{1'b0}};
            r_ex_valid  <= 1'b0;
            r_ex_data   <= {DATA_W{1'b0}};
            r_ex_dest   <= {REG_AW{1'b0}};
            r_md_cycles <= {CNT_W{1'b0}};
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_ex_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state     <= S_START;
                        r_opa       <= dx_opA;
                        r_opb       <= dx_opB;
                        r_rd        <= dx_rd;
                        r_kind_mult <= dx_mult;
                        r_ctrl_mult <= dx_mult;
                        r_ctrl_div  <= ~dx_mult;
                        r_cnt       <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                // md_ready here is left over from the previous op, so it is not looked at.
                S_START: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (md_ready) begin
                        r_state     <= S_DONE;
                        r_ex_valid  <= 1'b1;
                        r_ex_dest   <= md_exception ? STAT_RD : r_rd;
                        r_ex_data   <= md_exception ? exc_code(r_kind_mult) : md_result;
                        r_md_cycles <= w_cnt_inc;
                    end else if (w_wdog_hit) begin
                        r_state     <= S_DONE;
                        r_cnt       <= w_cnt_inc;
                        r_ex_valid  <= 1'b1;
                        r_ex_dest   <= STAT_RD;
                        r_ex_data   <= exc_code(r_kind_mult) | {1'b1, {(DATA_W-1){1'b0}}};
                        r_md_cycles <= w_cnt_inc;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl_MULT = r_ctrl_mult;
    assign ctrl_DIV  = r_ctrl_div;
    assign md_opA    = r_opa;
    assign md_opB    = r_opb;
    assign stall     = w_stall;
    assign ex_valid  = r_ex_valid;
    assign ex_data   = r_ex_data;
    assign ex_dest   = r_ex_dest;
    assign busy      = (r_state != S_IDLE);
    assign md_cycles = r_md_cycles;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl (watchdog case compiled in when MD_WATCHDOG_EN is defined).
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dx_mult, dx_div, flush, md_ready, md_exception;
    logic [31:0] dx_opA, dx_opB, md_result;
    logic [4:0]  dx_rd;
    logic        ctrl_MULT, ctrl_DIV, stall, ex_valid, busy;
    logic [31:0] md_opA, md_opB, ex_data;
    logic [4:0]  ex_dest;
    logic [7:0]  md_cycles;

    int checks = 0;
    int errors = 0;
    int mult_pulses = 0;
    int div_pulses = 0;

    md_issue_ctrl dut (
        .clock(clk), .reset(reset), .dx_mult(dx_mult), .dx_div(dx_div),
        .dx_opA(dx_opA), .dx_opB(dx_opB), .dx_rd(dx_rd), .flush(flush),
        .md_ready(md_ready), .md_result(md_result), .md_exception(md_exception),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
        .stall(stall), .ex_valid(ex_valid), .ex_data(ex_data), .ex_dest(ex_dest),
        .busy(busy), .md_cycles(md_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctrl_MULT) mult_pulses++;
        if (ctrl_DIV)  div_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue from IDLE, pass START, spend nwait WAIT cycles (ready on the last); returns in DONE.
    task automatic run_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int nwait, input logic exc,
                          input logic [31:0] res);
        dx_mult = is_mult; dx_div = ~is_mult; dx_opA = a; dx_opB = b; dx_rd = rd;
        #1 chk("issue_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("start_mult", {31'd0, ctrl_MULT}, {31'd0, is_mult});
        chk("start_div",  {31'd0, ctrl_DIV},  {31'd0, ~is_mult});
        chk("start_stall", {31'd0, stall}, 32'd1);
        chk("start_opA", md_opA, a);
        chk("start_opB", md_opB, b);
        md_ready = 1'b1; md_result = 32'hDEAD_BEEF;
        tick();
        md_ready = 1'b0;
        for (int i = 1; i <= nwait; i++) begin
            if (i == nwait) begin
                md_ready = 1'b1; md_result = res; md_exception = exc;
            end
            #1;
            chk("wait_stall", {31'd0, stall}, 32'd1);
            chk("wait_valid", {31'd0, ex_valid}, 32'd0);
            tick();
        end
        md_ready = 1'b0; md_exception = 1'b0; dx_mult = 1'b0; dx_div = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [4:0] dest, input logic [31:0] data,
                            input logic [7:0] cyc);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
        chk({tag, "_dest"},  {27'd0, ex_dest}, {27'd0, dest});
        chk({tag, "_data"},  ex_data, data);
        chk({tag, "_cyc"},   {24'd0, md_cycles}, {24'd0, cyc});
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; dx_mult = 1'b0; dx_div = 1'b0; flush = 1'b0; md_ready = 1'b0;
        md_exception = 1'b0; dx_opA = 32'd0; dx_opB = 32'd0; md_result = 32'd0; dx_rd = 5'd0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_cyc", {24'd0, md_cycles}, 32'd0);
        chk("rst_opA", md_opA, 32'd0);
        reset = 1'b1;
        tick();

        // mult 6*7, ready on the 10th WAIT cycle
        mult_pulses = 0; div_pulses = 0;
        run_op(1'b1, 32'd6, 32'd7, 5'd3, 10, 1'b0, 32'd42);
        chk_done("mul", 5'd3, 32'd42, 8'd10);
        tick();
        chk("mul_idle_valid", {31'd0, ex_valid}, 32'd0);
        chk("mul_idle_busy", {31'd0, busy}, 32'd0);
        chk("mul_pulses", mult_pulses, 32'd1);

        // div by zero with exception
        mult_pulses = 0; div_pulses = 0;
        run_op(1'b0, 32'd5, 32'd0, 5'd9, 3, 1'b1, 32'd0);
        chk_done("dive", 5'd30, 32'd5, 8'd3);
        tick();
        chk("dive_divp", div_pulses, 32'd1);
        chk("dive_mulp", mult_pulses, 32'd0);

        // mult exception followed by back-to-back div
        run_op(1'b1, 32'h7FFF_FFFF, 32'd2, 5'd4, 2, 1'b1, 32'd0);
        chk_done("mule", 5'd30, 32'd4, 8'd2);
        tick();
        run_op(1'b0, 32'd20, 32'd4, 5'd6, 1, 1'b0, 32'd5);
        chk_done("b2b", 5'd6, 32'd5, 8'd1);
        tick();

        // flush in IDLE blocks issue
        dx_mult = 1'b1; flush = 1'b1;
        #1 chk("iflush_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("iflush_busy", {31'd0, busy}, 32'd0);
        dx_mult = 1'b0; flush = 1'b0;

        // flush on third WAIT cycle
        dx_mult = 1'b1; dx_opA = 32'd3; dx_opB = 32'd3; dx_rd = 5'd2;
        tick(); tick(); tick(); tick();
        flush = 1'b1;
        #1 chk("wflush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0; dx_mult = 1'b0;
        chk("wflush_busy", {31'd0, busy}, 32'd0);
        chk("wflush_valid", {31'd0, ex_valid}, 32'd0);
        md_ready = 1'b1; md_result = 32'd9;
        tick();
        md_ready = 1'b0;
        chk("late_rdy_busy", {31'd0, busy}, 32'd0);
        chk("late_rdy_valid", {31'd0, ex_valid}, 32'd0);
        chk("late_rdy_cyc", {24'd0, md_cycles}, 32'd1);

        // reset mid-WAIT
        dx_mult = 1'b1; dx_opA = 32'd11; dx_opB = 32'd12; dx_rd = 5'd8;
        tick(); tick(); tick();
        dx_mult = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_opA", md_opA, 32'd0);
        chk("mrst_opB", md_opB, 32'd0);
        chk("mrst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        chk("mrst_ex", {ex_data[26:0], ex_dest}, 32'd0);
        chk("mrst_cyc", {24'd0, md_cycles}, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        run_op(1'b1, 32'd9, 32'd11, 5'd7, 1, 1'b0, 32'd99);
        chk_done("post", 5'd7, 32'd99, 8'd1);
        tick();

        // md_ready never arrives
        dx_mult = 1'b1; dx_opA = 32'd1; dx_opB = 32'd1; dx_rd = 5'd1;
        tick(); tick();
        dx_mult = 1'b0;
`ifdef MD_WATCHDOG_EN
        begin
            int n = 0;
            while (!ex_valid && n < 200) begin
                tick();
                n++;
            end
            chk("wdog_cycles", n, 32'd64);
            chk_done("wdog", 5'd30, 32'h8000_0004, 8'd64);
            tick();
        end
`else
        for (int i = 0; i < 70; i++) tick();
        chk("nowdog_busy", {31'd0, busy}, 32'd1);
        chk("nowdog_valid", {31'd0, ex_valid}, 32'd0);
        chk("nowdog_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
`endif
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
